// File: rtl/instr_mem_loadable_if.sv
// Loader and fetch-side signals of the loadable instruction memory.
// The master modport is the loader/core side; the slave modport is the memory.
interface instr_mem_loadable_if #(
  parameter int WORD_SIZE   = 8,
  parameter int FETCH_BYTES = 4,
  parameter int AW          = 10
);
  logic                           prog_valid;
  logic [WORD_SIZE-1:0]           prog_data;
  logic                           prog_last;
  logic                           prog_ready;
  logic                           reload;
  logic                           fetch_req;
  logic [AW-1:0]                  fetch_addr;
  logic                           fetch_ready;
  logic                           fetch_valid;
  logic [FETCH_BYTES*WORD_SIZE-1:0] fetch_data;
  logic                           fetch_misaligned;
  logic [AW:0]                    load_count;
  logic                           load_full;
  logic                           busy;

  modport master (
    output prog_valid, prog_data, prog_last, reload, fetch_req, fetch_addr,
    input  prog_ready, fetch_ready, fetch_valid, fetch_data, fetch_misaligned,
           load_count, load_full, busy
  );

  modport slave (
    input  prog_valid, prog_data, prog_last, reload, fetch_req, fetch_addr,
    output prog_ready, fetch_ready, fetch_valid, fetch_data, fetch_misaligned,
           load_count, load_full, busy
  );
endinterface

// File: rtl/instr_mem_loadable.sv
// Byte-organised instruction memory: zero-fill after reset, streaming load,
// then registered multi-byte fetches with misalignment flag.
module instr_mem_loadable #(
  parameter int MEM_SIZE    = 1024,
  parameter int WORD_SIZE   = 8,
  parameter int FETCH_BYTES = 4,
  parameter bit BIG_ENDIAN  = 1'b1,
  parameter int AW          = $clog2(MEM_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_mem_loadable_if.slave  bus
);
  localparam int FW = FETCH_BYTES * WORD_SIZE;

  typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_t;

  state_t               state;
  logic [AW-1:0]        clr_ptr;
  logic [WORD_SIZE-1:0] mem [MEM_SIZE];

  logic                 we;
  logic [AW-1:0]        waddr;
  logic [WORD_SIZE-1:0] wdata;
  logic [FW-1:0]        rd_word;
  logic                 prog_hs;

  assign prog_hs = (state == LOAD) && bus.prog_valid && bus.prog_ready;

  // Single write port shared by the zero-fill sweep and the loader.
  always_comb begin
    we    = 1'b0;
    waddr = clr_ptr;
    wdata = '0;
    if (!rst) begin
      if (state == CLEAR) begin
        we = 1'b1;
      end else if (prog_hs) begin
        we    = 1'b1;
        waddr = bus.load_count[AW-1:0];
        wdata = bus.prog_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Address arithmetic is AW bits wide so fetches wrap at the top of memory.
  for (genvar i = 0; i < FETCH_BYTES; i++) begin : g_rd
    logic [AW-1:0] a;
    assign a = bus.fetch_addr + AW'(i);
    if (BIG_ENDIAN) begin : g_be
      assign rd_word[(FETCH_BYTES-1-i)*WORD_SIZE +: WORD_SIZE] = mem[a];
    end else begin : g_le
      assign rd_word[i*WORD_SIZE +: WORD_SIZE] = mem[a];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= CLEAR;
      clr_ptr              <= '0;
      bus.load_count       <= '0;
      bus.load_full        <= 1'b0;
      bus.prog_ready       <= 1'b0;
      bus.fetch_ready      <= 1'b0;
      bus.busy             <= 1'b1;
      bus.fetch_valid      <= 1'b0;
      bus.fetch_data       <= '0;
      bus.fetch_misaligned <= 1'b0;
    end else begin
      bus.fetch_valid <= 1'b0;
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + AW'(1);
          if (clr_ptr == AW'(MEM_SIZE - 1)) begin
            state          <= LOAD;
            bus.prog_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (prog_hs) begin
            bus.load_count <= bus.load_count + (AW+1)'(1);
            if (bus.prog_last || bus.load_count == (AW+1)'(MEM_SIZE - 1)) begin
              // Hitting the top without a last marker is reported as load_full.
              bus.load_full   <= !bus.prog_last;
              state           <= RUN;
              bus.prog_ready  <= 1'b0;
              bus.fetch_ready <= 1'b1;
              bus.busy        <= 1'b0;
            end
          end
        end
        RUN: begin
          if (bus.fetch_req) begin
            bus.fetch_valid      <= 1'b1;
            bus.fetch_data       <= rd_word;
            bus.fetch_misaligned <= (bus.fetch_addr & AW'(FETCH_BYTES - 1)) != '0;
          end
          // A request in the reload cycle is still answered above.
          if (bus.reload) begin
            state           <= CLEAR;
            clr_ptr         <= '0;
            bus.load_count  <= '0;
            bus.load_full   <= 1'b0;
            bus.fetch_ready <= 1'b0;
            bus.busy        <= 1'b1;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end
endmodule

// File: doc/instr_mem_loadable.md
Name: instr_mem_loadable

Overview:
- Byte-organised instruction memory with a streaming program-load port and a registered, handshaked multi-byte fetch port.
- Sits between the boot/debug loader and the core's fetch stage.
- Zero-fills itself after reset, accepts a byte stream, then serves FETCH_BYTES-wide instruction fetches with misalignment reporting.

Parameters:
- MEM_SIZE, 1024, memory depth in bytes; power of two, at least 2*FETCH_BYTES.
- WORD_SIZE, 8, bits per memory location.
- FETCH_BYTES, 4, locations concatenated per fetch; power of two.
- BIG_ENDIAN, 1, 1: byte at addr in MSBs of fetch_data; 0: byte at addr in LSBs.
- AW, $clog2(MEM_SIZE), address width (derived).

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- prog_valid  in  1  load byte offered.
- prog_data  in  WORD_SIZE  load byte.
- prog_last  in  1  qualifies the final load byte.
- prog_ready  out  1  load byte accepted when prog_valid && prog_ready.
- reload  in  1  restart clear+load sequence; honoured only in RUN.
- fetch_req  in  1  fetch request.
- fetch_addr  in  AW  byte address of fetch.
- fetch_ready  out  1  high only in RUN; requests while low are dropped.
- fetch_valid  out  1  fetch_data valid this cycle.
- fetch_data  out  FETCH_BYTES*WORD_SIZE  fetched instruction.
- fetch_misaligned  out  1  fetch_addr % FETCH_BYTES != 0 for this response.
- load_count  out  AW+1  bytes written in current load.
- load_full  out  1  sticky: load stopped at MEM_SIZE without prog_last.
- busy  out  1  state is CLEAR or LOAD.

Behaviour:
- FSM states: CLEAR, LOAD, RUN. The reset state is CLEAR.
- Reset values: clr_ptr=0, load_count=0, load_full=0, fetch_valid=0, fetch_data=0, fetch_misaligned=0, prog_ready=0, fetch_ready=0, busy=1.
- CLEAR:
  - Writes 0 to location clr_ptr, one location per cycle, and increments clr_ptr.
  - After writing MEM_SIZE-1 (exactly MEM_SIZE cycles), goes to LOAD.
  - prog_ready=0 and fetch_ready=0 throughout.
- LOAD:
  - prog_ready=1 while load_count < MEM_SIZE.
  - On handshake, writes prog_data to location load_count[AW-1:0] and increments load_count.
  - Handshake with prog_last=1: writes the byte, then goes to RUN next cycle.
  - Handshake that makes load_count==MEM_SIZE with prog_last=0: sets load_full and goes to RUN.
  - prog_valid=0 cycles are idle; there is no timeout.
- RUN:
  - fetch_ready=1, prog_ready=0, busy=0.
  - A fetch_req sampled at edge N produces fetch_valid=1 at edge N+1 (1-cycle latency).
  - Back-to-back requests give back-to-back responses; no request produces fetch_valid=0 next cycle.
  - fetch_data is the concatenation of locations (fetch_addr+i) mod MEM_SIZE for i=0..FETCH_BYTES-1.
  - With BIG_ENDIAN=1, i=0 goes in the MSBs; with BIG_ENDIAN=0, i=0 goes in the LSBs.
  - Address arithmetic is AW bits wide and wraps at the top of memory.
  - Misaligned fetches still return data; fetch_misaligned is registered alongside fetch_valid.
  - fetch_data holds its last value when fetch_valid=0.
- Reload:
  - reload=1 in RUN goes to CLEAR next cycle and clears clr_ptr, load_count and load_full.
  - A fetch_req in that same cycle is still answered.
- Reload and rst are ignored in no state; rst has priority everywhere.
  - rst mid-CLEAR or mid-LOAD restarts CLEAR from 0.
  - A response pending at rst is discarded (fetch_valid=0).
- Memory array is single-write, one async/combinational read of FETCH_BYTES locations into the output register; no per-location reset logic.

Test Plan:
- MEM_SIZE=16, FETCH_BYTES=4, BIG_ENDIAN=1; rst 1 cycle -> busy=1 and prog_ready=0 for 16 cycles, then prog_ready=1 on cycle 17.
- Load bytes ff,c4,a3,03,00,83,23,83 (last on 83); fetch addr 0 -> next cycle fetch_valid=1, data=ffc4a303, misaligned=0; fetch addr 4 -> 00832383.
- Same load, BIG_ENDIAN=0, fetch addr 0 -> 03a3c4ff.
- Load 8 bytes, fetch addr 14 -> data = {mem[14],mem[15],mem[0],mem[1]} = 0000ffc4, misaligned=1.
- Load 16 bytes without prog_last -> load_full=1, load_count=16, RUN entered, prog_ready=0 while 17th byte held valid.
- Fetch requests on 3 consecutive cycles -> 3 consecutive fetch_valid.
  - Assert reload, then rst mid-LOAD -> CLEAR restarts, load_count=0, old contents read 0 after a new empty load (prog_last on first byte 00).
